hex_scan_driver: RTL and testbench
==================================

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 The block SHALL expose parameter SCAN_DIV, default 50000, setting the number of clk cycles each digit is displayed.
REQ-002 The block SHALL expose parameter DEAD_CYC, default 8, setting the number of clk cycles all anodes are off after each digit switch; DEAD_CYC < SCAN_DIV.
REQ-003 The block SHALL expose parameter SEG_ACTIVE_LOW, default 1, which inverts seg and an when 1.
REQ-004 The block SHALL have a single clock and asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 digit0..digit3  input  4 each  hex values from the per-digit PIO out_port outputs.
REQ-008 blank_mask  input  4  bit i=1 blanks digit i.
REQ-009 blink_mask  input  4  bit i=1 makes digit i blink.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-011 an  output  4  one-hot digit enable.
REQ-012 frame_start  output  1  one-cycle pulse when the shadow snapshot is taken.

Function
REQ-013 Prescaler: 0..SCAN_DIV-1 counter, wraps to 0; scan_tick is asserted in the cycle the counter equals SCAN_DIV-1.
REQ-014 Digit index: 2-bit register, advances on scan_tick, wraps 3->0.
REQ-015 Snapshot: on scan_tick with index==3, digit0..3, blank_mask and blink_mask SHALL be captured into shadow registers; frame_start pulses that same cycle; inputs changing mid-frame SHALL NOT affect the current frame.
REQ-016 Blink: 8-bit counter increments on every scan_tick and wraps 255->0; blink phase = counter bit 7.
REQ-017 Digit i is dark when shadow blank bit is 1, or when shadow blink bit is 1 and blink phase is 1.
REQ-018 Dead time: for the first DEAD_CYC cycles after each index change (prescaler < DEAD_CYC), all anodes SHALL be inactive.
REQ-019 Outside dead time, an SHALL assert only bit [index], and only if that digit is not dark; otherwise all anodes are inactive.
REQ-020 Decode (active-high, {g..a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-021 seg and an SHALL be registered: they reflect index/prescaler state with exactly one clk of latency, and never glitch between digits.
REQ-022 With the anodes off, seg SHALL output all segments off.
REQ-023 Simultaneous snapshot and blink-counter wrap SHALL both take effect in the same cycle.

Reset
REQ-024 Reset SHALL clear the prescaler, index, blink counter, shadow digits and shadow masks to 0, and frame_start to 0.
REQ-025 During reset, an and seg SHALL drive all-inactive (all 1s when SEG_ACTIVE_LOW=1).
REQ-026 A reset mid-frame SHALL restart scanning at digit 0 with a dead-time window; digits SHALL show 0 until the first snapshot.

Structure
REQ-027 A shared package hex_disp_pkg SHALL hold the 16-entry segment table constant, the digit count (4) and the index type.
REQ-028 One combinational sub-module, hex7seg_decode (4-bit in, 7-bit active-high out), SHALL implement REQ-020; polarity inversion stays in hex_scan_driver.

Verification
REQ-029 Use SCAN_DIV=4, DEAD_CYC=1, SEG_ACTIVE_LOW=1; digits 1,2,3,4; masks 0 -> after the first frame_start, an cycles 1110,1101,1011,0111 with seg 1111001,0100100,0110000,0011001, each preceded by one all-off cycle.
REQ-030 Change digit2 from 3 to F mid-frame -> the current frame still shows 0110000 on digit 2; the next frame shows 0001110.
REQ-031 blank_mask=0100 -> an never equals 1011; seg=1111111 in that slot.
REQ-032 blink_mask=0001 -> digit 0 is shown for 128 scan_ticks, then dark for 128, and repeats.
REQ-033 Assert reset for 2 cycles mid-digit-2 -> an=1111 and seg=1111111 during reset; after release, the first lit digit is digit 0 showing 1000000.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// ---------------------------------------------------------------------------
// hex_disp_pkg
// Shared definitions for the multiplexed 4-digit hex display:
//   NUM_DIGITS  - number of scanned digits
//   digit_idx_t - scan index type (one value per digit)
//   hex_t/seg_t - nibble and 7-segment ({g,f,e,d,c,b,a}) vector types
//   frame_t     - one display frame as held in the shadow registers
//   SEG_TABLE   - active-high segment pattern for each hex value
// ---------------------------------------------------------------------------
package hex_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] hex_t;
    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] blank;
        logic [NUM_DIGITS-1:0] blink;
        hex_t [NUM_DIGITS-1:0] digits;
    } frame_t;

    // Glyphs use the lower-case forms for b and d so they differ from 8 and 0.
    localparam seg_t SEG_TABLE [0:15] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

endpackage

// File: rtl/hex7seg_decode.sv
// ---------------------------------------------------------------------------
// hex7seg_decode
// Purely combinational hex-to-7-segment decoder, active-high output.
//   hex - 4-bit value to display
//   seg - segments {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module hex7seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/hex_scan_driver.sv
// ---------------------------------------------------------------------------
// hex_scan_driver
// Time-multiplexed driver for a 4-digit common-anode/cathode hex display.
// Each digit is shown for SCAN_DIV clocks, with the first DEAD_CYC clocks of
// every digit slot blanked to stop ghosting. A whole frame (4 digits plus
// blank/blink masks) is snapshotted at the end of digit 3 so inputs changing
// mid-frame never tear the display.
//
// Parameters
//   SCAN_DIV       - clocks per digit slot
//   DEAD_CYC       - clocks of all-anodes-off at the start of each slot
//   SEG_ACTIVE_LOW - 1 inverts seg and an at the pins
// Ports
//   clk            - clock, rising edge
//   reset          - asynchronous, active-high reset
//   digit0..digit3 - hex values to display
//   blank_mask     - bit i = 1 blanks digit i
//   blink_mask     - bit i = 1 blinks digit i
//   seg            - segments {g,f,e,d,c,b,a}, registered
//   an             - one-hot digit enable, registered
//   frame_start    - one-clock pulse as the new snapshot becomes active
// ---------------------------------------------------------------------------
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYC       = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blank_mask,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int              PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] DEAD_LIM = PRE_W'(DEAD_CYC);
    localparam digit_idx_t      LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    // XOR masks: all-ones flips polarity, all-zeros passes through. XORing an
    // all-off active-high value gives the inactive pin level either way.
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] AN_POL  = {4{SEG_ACTIVE_LOW}};

    logic [PRE_W-1:0] prescaler;
    digit_idx_t       idx;
    logic [7:0]       blink_cnt;
    frame_t           shadow;

    logic             scan_tick;
    logic             snap;
    hex_t             cur_hex;
    logic             dark;
    logic             lit;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_ah;
    logic [3:0]       an_ah;

    assign scan_tick = (prescaler == PRE_LAST);
    assign snap      = scan_tick && (idx == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (scan_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Index and blink counter both wrap naturally at their widths, so a
    // snapshot tick that also rolls blink_cnt over 255->0 needs no priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            blink_cnt <= '0;
        end else if (scan_tick) begin
            idx       <= idx + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // NOTE: the shadow frame is a handful of flops, not a RAM, so it is reset
    // to show zeros until the first snapshot after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (snap) begin
                shadow.digits <= {digit3, digit2, digit1, digit0};
                shadow.blank  <= blank_mask;
                shadow.blink  <= blink_mask;
            end
        end
    end

    // NOTE: every signal written here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        cur_hex = shadow.digits[idx];
        dark    = shadow.blank[idx] | (shadow.blink[idx] & blink_cnt[7]);
        lit     = (prescaler >= DEAD_LIM) && !dark;
        an_ah   = lit ? (4'b0001 << idx) : 4'b0000;
    end

    hex7seg_decode u_decode (
        .hex (cur_hex),
        .seg (dec_seg)
    );

    // Segments are forced off whenever no anode is driven.
    assign seg_ah = lit ? dec_seg : 7'b0000000;

    // Registering both seg and an together keeps them switching on the same
    // edge, so no segment pattern ever leaks onto the wrong digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_POL;
            an  <= AN_POL;
        end else begin
            seg <= SEG_POL ^ seg_ah;
            an  <= AN_POL ^ an_ah;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_driver
// Directed bench for hex_scan_driver with SCAN_DIV=4, DEAD_CYC=1 and
// active-low outputs. Each digit slot is 4 clocks: one dead clock followed
// by three lit clocks. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hex_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] blank_mask, blink_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] blink_model;

    always #5 clk = ~clk;

    hex_scan_driver #(
        .SCAN_DIV       (4),
        .DEAD_CYC       (1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    // Active-low pin patterns, hand-inverted from the active-high glyph table.
    function automatic logic [6:0] seg_lo(input logic [3:0] hex);
        case (hex)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'hF:    return 7'b0001110;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        check(tag, 16'(seen), 16'd1);
    endtask

    // One digit slot: dead clock, then three lit (or dark) clocks.
    task automatic check_slot(input string tag, input int k, input logic [3:0] hex, input logic dark);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(negedge clk);
        check($sformatf("%s_d%0d_dead_an", tag, k), 16'(an), 16'h000F);
        check($sformatf("%s_d%0d_dead_seg", tag, k), 16'(seg), 16'h007F);
        if (dark) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
        end else begin
            exp_an  = ~(4'b0001 << k);
            exp_seg = seg_lo(hex);
        end
        repeat (3) begin
            @(negedge clk);
            check($sformatf("%s_d%0d_an", tag, k), 16'(an), 16'(exp_an));
            check($sformatf("%s_d%0d_seg", tag, k), 16'(seg), 16'(exp_seg));
        end
    endtask

    // A full frame ends on the negedge where the next frame_start is visible.
    task automatic check_frame(input string tag, input logic [15:0] digs, input logic [3:0] dark);
        for (int k = 0; k < 4; k++) begin
            check_slot(tag, k, digs[4*k +: 4], dark[k]);
        end
        check($sformatf("%s_fs", tag), 16'(frame_start), 16'd1);
    endtask

    initial begin
        reset      = 1'b1;
        digit0     = 4'h1;
        digit1     = 4'h2;
        digit2     = 4'h3;
        digit3     = 4'h4;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;

        // Reset state: everything inactive.
        @(negedge clk);
        check("rst_an", 16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_fs", 16'(frame_start), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Scan restarts at digit 0 with a dead clock, showing 0 before any snapshot.
        @(negedge clk);
        check("boot_dead_an", 16'(an), 16'h000F);
        check("boot_dead_seg", 16'(seg), 16'h007F);
        @(negedge clk);
        check("boot_d0_an", 16'(an), 16'h000E);
        check("boot_d0_seg", 16'(seg), 16'h0040);

        wait_frame("first_frame");

        // Frame 1: digits 1,2,3,4; digit2 changes to F mid-frame but is not shown yet.
        check_slot("f1", 0, 4'h1, 1'b0);
        digit2 = 4'hF;
        check_slot("f1", 1, 4'h2, 1'b0);
        check_slot("f1", 2, 4'h3, 1'b0);
        check_slot("f1", 3, 4'h4, 1'b0);
        check("f1_fs", 16'(frame_start), 16'd1);

        // Frame 2 shows F on digit 2; blank_mask set now lands in frame 3.
        blank_mask = 4'b0100;
        check_frame("f2", 16'h4F21, 4'b0000);

        // Frame 3: digit 2 blanked. Blink on digit 0 lands in frame 4.
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        check_frame("f3", 16'h4F21, 4'b0100);

        // Frames 4..69: blink counter is 4*frame at frame start; phase is bit 7.
        // Frames 32..63 dark on digit 0, frame 64 wraps the counter back to lit.
        for (int fi = 4; fi <= 69; fi++) begin
            if (fi == 69) blink_mask = 4'b0000;
            blink_model = 8'(4 * fi);
            check_frame($sformatf("blink%0d", fi), 16'h4F21, {3'b000, blink_model[7]});
        end

        // Frame 70: reset while digit 2 is lit.
        check_slot("f70", 0, 4'h1, 1'b0);
        check_slot("f70", 1, 4'h2, 1'b0);
        @(negedge clk);
        check("f70_d2_dead_an", 16'(an), 16'h000F);
        @(negedge clk);
        check("f70_d2_an", 16'(an), 16'h000B);
        check("f70_d2_seg", 16'(seg), 16'h000E);
        reset = 1'b1;
        #1;
        check("mid_rst_an", 16'(an), 16'h000F);
        check("mid_rst_seg", 16'(seg), 16'h007F);
        check("mid_rst_fs", 16'(frame_start), 16'd0);
        @(negedge clk);
        check("mid_rst_an2", 16'(an), 16'h000F);
        check("mid_rst_seg2", 16'(seg), 16'h007F);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rerun_dead_an", 16'(an), 16'h000F);
        check("rerun_dead_seg", 16'(seg), 16'h007F);
        @(negedge clk);
        check("rerun_d0_an", 16'(an), 16'h000E);
        check("rerun_d0_seg", 16'(seg), 16'h0040);

        wait_frame("rerun_frame");
        check_frame("rerun", 16'h4F21, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
